// File: rtl/fft_peak_pkg.sv
// Shared types for the FFT peak detector: FSM states, the bin/magnitude
// candidate struct and the bin-index width derivation.
package fft_peak_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StFlush,
    StDone
  } state_t;

  // Candidate fields are sized to bound any supported BIN_W / MAG_W (both <= 16).
  // Narrower values are zero-extended, so unsigned compares are unaffected.
  localparam int unsigned CAND_BIN_W = 16;
  localparam int unsigned CAND_MAG_W = 16;

  typedef struct packed {
    logic [CAND_BIN_W-1:0] bin;
    logic [CAND_MAG_W-1:0] mag;
  } cand_t;

  function automatic int unsigned bin_w(input int unsigned fft_n);
    return $clog2(fft_n);
  endfunction

endpackage

// File: rtl/fft_peak_detect_if.sv
// Spectrum-in / peak-out bundle for fft_peak_detect.
// Optional PEAK_THRESH_EN adds threshold (in) and peak_found (out).
interface fft_peak_detect_if #(
  parameter int unsigned FFT_N = 64,
  parameter int unsigned MAG_W = 12
) ();
  localparam int unsigned BIN_W = fft_peak_pkg::bin_w(FFT_N);

  logic             next_in;
  logic [MAG_W-1:0] mag1;
  logic [MAG_W-1:0] mag2;
  logic [BIN_W-1:0] peak_bin;
  logic [MAG_W-1:0] peak_mag;
  logic             peak_valid;
  logic             busy;
  logic             overrun;
`ifdef PEAK_THRESH_EN
  logic [MAG_W-1:0] threshold;
  logic             peak_found;

  modport master (
    output next_in, mag1, mag2, threshold,
    input  peak_bin, peak_mag, peak_valid, busy, overrun, peak_found
  );
  modport slave (
    input  next_in, mag1, mag2, threshold,
    output peak_bin, peak_mag, peak_valid, busy, overrun, peak_found
  );
`else
  modport master (
    output next_in, mag1, mag2,
    input  peak_bin, peak_mag, peak_valid, busy, overrun
  );
  modport slave (
    input  next_in, mag1, mag2,
    output peak_bin, peak_mag, peak_valid, busy, overrun
  );
`endif

endinterface

// File: rtl/fft_peak_pair_cmp.sv
// Combinational winner of two masked bin/magnitude candidates.
// Larger magnitude wins; on equal magnitude the lower bin wins.
module fft_peak_pair_cmp
  import fft_peak_pkg::*;
(
  input  cand_t a,
  input  logic  a_ok,
  input  cand_t b,
  input  logic  b_ok,
  output cand_t win,
  output logic  win_ok
);

  logic b_wins;

  // Pick b only when it is unmasked and strictly better than a.
  always_comb begin
    b_wins = 1'b0;
    if (b_ok) begin
      if (!a_ok) begin
        b_wins = 1'b1;
      end else if (b.mag > a.mag) begin
        b_wins = 1'b1;
      end else if ((b.mag == a.mag) && (b.bin < a.bin)) begin
        b_wins = 1'b1;
      end
    end
    win    = b_wins ? b : a;
    win_ok = a_ok | b_ok;
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over a streamed magnitude spectrum (two bins per cycle).
// Optional PEAK_THRESH_EN adds a threshold compare reported as peak_found.
module fft_peak_detect
  import fft_peak_pkg::*;
#(
  parameter int unsigned FFT_N   = 64,
  parameter int unsigned MAG_W   = 12,
  parameter int unsigned MIN_BIN = 1,
  parameter int unsigned MAX_BIN = FFT_N / 2 - 1
) (
  input logic              clk,
  input logic              reset,
  fft_peak_detect_if.slave bus
);

  localparam int unsigned      BIN_W     = bin_w(FFT_N);
  localparam int unsigned      PAIRS     = FFT_N / 2;
  localparam logic [BIN_W-1:0] LO_BIN    = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] HI_BIN    = BIN_W'(MAX_BIN);
  localparam logic [BIN_W-2:0] LAST_PAIR = (BIN_W-1)'(PAIRS - 1);

  state_t           state;
  logic [BIN_W-2:0] pair_cnt;
  logic [BIN_W-1:0] even_bin, odd_bin;
  logic             even_ok, odd_ok;
  cand_t            even_cand, odd_cand;
  cand_t            pair_win, s1, best, next_best;
  logic             pair_ok, s1_vld, next_ok;

  // Bin indices of the pair on the bus this cycle, and the search-window mask.
  always_comb begin
    even_bin  = {pair_cnt, 1'b0};
    odd_bin   = {pair_cnt, 1'b1};
    even_ok   = (even_bin >= LO_BIN) && (even_bin <= HI_BIN);
    odd_ok    = (odd_bin >= LO_BIN) && (odd_bin <= HI_BIN);
    even_cand = '{bin: CAND_BIN_W'(even_bin), mag: CAND_MAG_W'(bus.mag1)};
    odd_cand  = '{bin: CAND_BIN_W'(odd_bin), mag: CAND_MAG_W'(bus.mag2)};
  end

  fft_peak_pair_cmp u_pair_cmp (
    .a      (even_cand),
    .a_ok   (even_ok),
    .b      (odd_cand),
    .b_ok   (odd_ok),
    .win    (pair_win),
    .win_ok (pair_ok)
  );

  // Running maximum sits in a; it always holds the lower bin, so ties keep it.
  fft_peak_pair_cmp u_max_cmp (
    .a      (best),
    .a_ok   (1'b1),
    .b      (s1),
    .b_ok   (s1_vld),
    .win    (next_best),
    .win_ok (next_ok)
  );

  // Two-stage datapath: registered pair winner, then running-maximum update.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s1_vld <= 1'b0;
      best   <= '0;
    end else if (bus.next_in) begin
      s1     <= '0;
      s1_vld <= 1'b0;
      best   <= '{bin: CAND_BIN_W'(MIN_BIN), mag: '0};
    end else begin
      s1     <= pair_win;
      s1_vld <= (state == StCollect) && pair_ok;
      if (next_ok) best <= next_best;
    end
  end

  // Frame FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      pair_cnt       <= '0;
      bus.peak_bin   <= '0;
      bus.peak_mag   <= '0;
      bus.peak_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef PEAK_THRESH_EN
      bus.peak_found <= 1'b0;
`endif
    end else begin
      bus.peak_valid <= 1'b0;
      bus.overrun    <= 1'b0;
      if (bus.next_in) begin
        // Any next_in starts a frame; only an unfinished frame counts as overrun.
        state       <= StCollect;
        pair_cnt    <= '0;
        bus.busy    <= 1'b1;
        bus.overrun <= (state == StCollect) || (state == StFlush);
      end else begin
        unique case (state)
          StIdle: begin
            bus.busy <= 1'b0;
          end
          StCollect: begin
            pair_cnt <= pair_cnt + 1'b1;
            if (pair_cnt == LAST_PAIR) state <= StFlush;
          end
          StFlush: begin
            // Last pair is in stage 1 now; its merge result is the frame answer.
            state          <= StDone;
            bus.peak_valid <= 1'b1;
            bus.peak_bin   <= next_best.bin[BIN_W-1:0];
            bus.peak_mag   <= next_best.mag[MAG_W-1:0];
`ifdef PEAK_THRESH_EN
            bus.peak_found <= next_best.mag >= CAND_MAG_W'(bus.threshold);
`endif
          end
          StDone: begin
            state    <= StIdle;
            bus.busy <= 1'b0;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed self-checking bench for fft_peak_detect (FFT_N=64, MAG_W=12).
// Build with PEAK_THRESH_EN defined to also exercise peak_found.
module tb_fft_peak_detect;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.FFT_N(64), .MAG_W(12)) bus ();

  fft_peak_detect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] spec [64];
  int          s_cyc;

  // Monitor-owned records.
  int          valid_cnt = 0;
  int          valid_cyc = -1;
  int          ovr_cnt = 0;
  int          ovr_cyc = -1;
  logic [5:0]  res_bin;
  logic [11:0] res_mag;
  logic        res_found;
  logic        busy_log [4096];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_log[cyc[11:0]] = bus.busy;
    if (bus.peak_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      res_bin   = bus.peak_bin;
      res_mag   = bus.peak_mag;
`ifdef PEAK_THRESH_EN
      res_found = bus.peak_found;
`else
      res_found = 1'b1;
`endif
    end
    if (bus.overrun) begin
      ovr_cnt = ovr_cnt + 1;
      ovr_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    step();
    bus.next_in = 1'b1;
    bus.mag1    = '0;
    bus.mag2    = '0;
    s_cyc       = cyc;
  endtask

  task automatic feed_pairs(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      bus.next_in = 1'b0;
      bus.mag1    = spec[2*k];
      bus.mag2    = spec[2*k+1];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      bus.next_in = 1'b0;
      bus.mag1    = '0;
      bus.mag2    = '0;
    end
  endtask

  task automatic set_spec(input logic [11:0] base);
    for (int i = 0; i < 64; i++) spec[i] = base;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    checks++;
    if ({bus.peak_bin, bus.peak_mag, bus.peak_valid, bus.busy, bus.overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got bin=%0d mag=%0d v=%0b busy=%0b ovr=%0b want all 0",
               bus.peak_bin, bus.peak_mag, bus.peak_valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_single_tone();
    int v0 = valid_cnt;
    int o0 = ovr_cnt;
    int s;
    set_spec(12'd20);
    spec[10] = 12'd500;
    begin_frame();
    s = s_cyc;
    feed_pairs(32);
    idle(4);
    checks++;
    if (valid_cnt - v0 != 1 || valid_cyc != s + 34) begin
      failures++;
      $display("FAIL tone_valid got count=%0d at S+%0d want 1 at S+34", valid_cnt - v0,
               valid_cyc - s);
    end
    checks++;
    if (res_bin !== 6'd10 || res_mag !== 12'd500) begin
      failures++;
      $display("FAIL tone_result got bin=%0d mag=%0d want bin=10 mag=500", res_bin, res_mag);
    end
    checks++;
    if (busy_log[s[11:0]] !== 1'b0 || busy_log[12'(s + 1)] !== 1'b1 ||
        busy_log[12'(s + 34)] !== 1'b1 || busy_log[12'(s + 35)] !== 1'b0) begin
      failures++;
      $display("FAIL tone_busy got S=%0b S+1=%0b S+34=%0b S+35=%0b want 0 1 1 0",
               busy_log[s[11:0]], busy_log[12'(s + 1)], busy_log[12'(s + 34)],
               busy_log[12'(s + 35)]);
    end
    checks++;
    if (ovr_cnt != o0) begin
      failures++;
      $display("FAIL tone_overrun got %0d pulses want 0", ovr_cnt - o0);
    end
  endtask

  task automatic test_dc_mask();
    set_spec(12'd5);
    spec[0]  = 12'd4095;
    spec[7]  = 12'd300;
    spec[40] = 12'd4000;
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (res_bin !== 6'd7 || res_mag !== 12'd300) begin
      failures++;
      $display("FAIL dc_mask got bin=%0d mag=%0d want bin=7 mag=300", res_bin, res_mag);
    end
  endtask

  task automatic test_ties();
    set_spec(12'd0);
    spec[12] = 12'd800;
    spec[13] = 12'd800;
    spec[25] = 12'd800;
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (res_bin !== 6'd12 || res_mag !== 12'd800) begin
      failures++;
      $display("FAIL tie got bin=%0d mag=%0d want bin=12 mag=800", res_bin, res_mag);
    end
    set_spec(12'd0);
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (res_bin !== 6'd1 || res_mag !== 12'd0) begin
      failures++;
      $display("FAIL all_zero got bin=%0d mag=%0d want bin=1 mag=0", res_bin, res_mag);
    end
  endtask

  task automatic test_abort();
    int v0 = valid_cnt;
    int o0 = ovr_cnt;
    int s;
    set_spec(12'd0);
    spec[5] = 12'd3000;
    begin_frame();
    s = s_cyc;
    feed_pairs(9);
    set_spec(12'd0);
    spec[3] = 12'd900;
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (ovr_cnt - o0 != 1 || ovr_cyc != s + 11) begin
      failures++;
      $display("FAIL abort_overrun got count=%0d at S+%0d want 1 at S+11", ovr_cnt - o0,
               ovr_cyc - s);
    end
    checks++;
    if (valid_cnt - v0 != 1 || valid_cyc != s + 44) begin
      failures++;
      $display("FAIL abort_valid got count=%0d at S+%0d want 1 at S+44", valid_cnt - v0,
               valid_cyc - s);
    end
    checks++;
    if (res_bin !== 6'd3 || res_mag !== 12'd900) begin
      failures++;
      $display("FAIL abort_result got bin=%0d mag=%0d want bin=3 mag=900", res_bin, res_mag);
    end
  endtask

  task automatic test_mid_reset();
    int v0;
    set_spec(12'd0);
    spec[8] = 12'd1000;
    begin_frame();
    v0 = valid_cnt;
    feed_pairs(14);
    step();
    bus.mag1 = '0;
    bus.mag2 = '0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.peak_bin, bus.peak_mag, bus.peak_valid, bus.busy, bus.overrun} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got bin=%0d mag=%0d v=%0b busy=%0b ovr=%0b want all 0",
               bus.peak_bin, bus.peak_mag, bus.peak_valid, bus.busy, bus.overrun);
    end
    idle(40);
    checks++;
    if (valid_cnt != v0) begin
      failures++;
      $display("FAIL midreset_novalid got %0d pulses want 0", valid_cnt - v0);
    end
    set_spec(12'd0);
    spec[20] = 12'd700;
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (valid_cnt - v0 != 1 || res_bin !== 6'd20 || res_mag !== 12'd700) begin
      failures++;
      $display("FAIL after_reset got count=%0d bin=%0d mag=%0d want 1 bin=20 mag=700",
               valid_cnt - v0, res_bin, res_mag);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    int o0 = ovr_cnt;
    int s;
    set_spec(12'd0);
    spec[9] = 12'd100;
    begin_frame();
    s = s_cyc;
    feed_pairs(32);
    idle(1);
    set_spec(12'd0);
    spec[30] = 12'd2000;
    begin_frame();
    checks++;
    if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 6'd9 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got v=%0b bin=%0d busy=%0b want v=1 bin=9 busy=1",
               bus.peak_valid, bus.peak_bin, bus.busy);
    end
    feed_pairs(32);
    idle(4);
    checks++;
    if (valid_cnt - v0 != 2 || valid_cyc != s + 68) begin
      failures++;
      $display("FAIL b2b_valid got count=%0d last at S+%0d want 2 last at S+68",
               valid_cnt - v0, valid_cyc - s);
    end
    checks++;
    if (res_bin !== 6'd30 || res_mag !== 12'd2000 || ovr_cnt != o0) begin
      failures++;
      $display("FAIL b2b_second got bin=%0d mag=%0d ovr=%0d want bin=30 mag=2000 ovr=0",
               res_bin, res_mag, ovr_cnt - o0);
    end
  endtask

`ifdef PEAK_THRESH_EN
  task automatic test_threshold();
    bus.threshold = 12'd600;
    set_spec(12'd0);
    spec[10] = 12'd500;
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (res_found !== 1'b0) begin
      failures++;
      $display("FAIL thresh_below got found=%0b want 0", res_found);
    end
    spec[10] = 12'd600;
    begin_frame();
    feed_pairs(32);
    idle(4);
    checks++;
    if (res_found !== 1'b1 || bus.peak_found !== 1'b1) begin
      failures++;
      $display("FAIL thresh_equal got found=%0b held=%0b want 1 1", res_found, bus.peak_found);
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.next_in = 1'b0;
    bus.mag1    = '0;
    bus.mag2    = '0;
`ifdef PEAK_THRESH_EN
    bus.threshold = 12'd600;
`endif
    set_spec(12'd0);
    test_reset();
    test_single_tone();
    test_dc_mask();
    test_ties();
    test_abort();
    test_mid_reset();
    test_back_to_back();
`ifdef PEAK_THRESH_EN
    test_threshold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
